multi_seq_ctrl: RTL and testbench

//  Operand sequencer and result collector wrapped around the serial shift-add 16x16 multiplier (multi_16to16).
//  - Buffers incoming operand pairs in a small FIFO.
//  - Presents one pair to the multiplier and frames its run by driving the multiplier's reset/start.
//  - Counts the fixed serial latency, captures the product and holds it on a valid/ready output port.
//  - Gives the serial multiplier a stream handshake for the surrounding datapath.

---
 rtl/multi_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_multi_seq_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_seq_ctrl.sv
// Operand sequencer around the serial shift-add multiplier: queues operand pairs,
// frames each multiplier run, and holds the product on a valid/ready result port.
module multi_seq_ctrl #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 4,
  parameter int MUL_CYCLES = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [WIDTH-1:0]             in_a_i,
  input  logic [WIDTH-1:0]             in_b_i,
  output logic [WIDTH-1:0]             mul_a_o,
  output logic [WIDTH-1:0]             mul_b_o,
  output logic                         mul_rst_o,
  input  logic [WIDTH-1:0]             mul_y_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [WIDTH-1:0]             res_o,
  output logic                         busy_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   mem_a_reg [DEPTH];
  logic [WIDTH-1:0]   mem_b_reg [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [LVL_W-1:0]   level_reg;
  logic               avail_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   mul_a_reg;
  logic [WIDTH-1:0]   mul_b_reg;
  logic               mul_rst_reg;
  logic               out_valid_reg;
  logic [WIDTH-1:0]   res_reg;
  logic               push;
  logic               pop;
  logic               fifo_nonempty;

  assign fifo_nonempty = (level_reg != '0);
  assign in_ready_o    = (level_reg != LVL_W'(DEPTH));
  assign push          = in_valid_i && in_ready_o;

  // IDLE launches one cycle after the FIFO is seen non-empty, which fixes the
  // accept-to-result latency at MUL_CYCLES+3 regardless of when the word arrived.
  always_comb begin
    pop = 1'b0;
    case (state_reg)
      IDLE:    pop = avail_reg && fifo_nonempty;
      DONE:    pop = out_ready_i && fifo_nonempty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_a_reg[wr_ptr_reg] <= in_a_i;
      mem_b_reg[wr_ptr_reg] <= in_b_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      avail_reg  <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
      avail_reg <= fifo_nonempty;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      mul_a_reg     <= '0;
      mul_b_reg     <= '0;
      mul_rst_reg   <= 1'b1;
      out_valid_reg <= 1'b0;
      res_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          mul_rst_reg <= 1'b1;
          if (pop) begin
            mul_a_reg <= mem_a_reg[rd_ptr_reg];
            mul_b_reg <= mem_b_reg[rd_ptr_reg];
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          // Multiplier has sampled the operands while held in reset; release it.
          mul_rst_reg <= 1'b0;
          cnt_reg     <= '0;
          state_reg   <= RUN;
        end
        RUN: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(MUL_CYCLES - 1)) begin
            res_reg       <= mul_y_i;
            out_valid_reg <= 1'b1;
            mul_rst_reg   <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          mul_rst_reg <= 1'b1;
          if (out_ready_i) begin
            out_valid_reg <= 1'b0;
            if (pop) begin
              mul_a_reg <= mem_a_reg[rd_ptr_reg];
              mul_b_reg <= mem_b_reg[rd_ptr_reg];
              state_reg <= LOAD;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mul_a_o     = mul_a_reg;
  assign mul_b_o     = mul_b_reg;
  assign mul_rst_o   = mul_rst_reg;
  assign out_valid_o = out_valid_reg;
  assign res_o       = res_reg;
  assign busy_o      = (state_reg != IDLE);
  assign level_o     = level_reg;

endmodule

// File: tb/tb_multi_seq_ctrl.sv
// Directed bench for multi_seq_ctrl with a behavioural serial multiplier whose
// product only becomes visible after MUL_CYCLES-1 cycles out of reset.
module tb_multi_seq_ctrl;

  localparam int WIDTH      = 16;
  localparam int DEPTH      = 4;
  localparam int MUL_CYCLES = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             mul_rst;
  logic [WIDTH-1:0] mul_y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             busy;
  logic [2:0]       level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_seq_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_a_i(in_a), .in_b_i(in_b),
    .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_rst_o(mul_rst), .mul_y_i(mul_y),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .res_o(res),
    .busy_o(busy), .level_o(level)
  );

  // Multiplier model: samples operands while in reset, product final after
  // MUL_CYCLES-1 completed cycles of run, zero before that.
  logic [WIDTH-1:0] m_a, m_b;
  int               m_cnt;
  logic [31:0]      m_prod;
  always @(posedge clk) begin
    if (mul_rst) begin
      m_a   <= mul_a;
      m_b   <= mul_b;
      m_cnt <= 0;
    end else if (m_cnt < 100) begin
      m_cnt <= m_cnt + 1;
    end
  end
  assign m_prod = {16'h0, m_a} * {16'h0, m_b};
  assign mul_y  = (!mul_rst && m_cnt >= MUL_CYCLES - 1) ? m_prod[15:0] : '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("valid_timeout", {31'h0, out_valid}, 32'h1);
    $display("txn result res=%h after %0d cycles", res, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int n;
  int pulses;
  int exp4 [5];

  initial begin
    exp4 = '{2, 12, 30, 56, 90};
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_level", {29'h0, level}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_res", {16'h0, res}, 32'h0);
    check("rst_mul_a", {16'h0, mul_a}, 32'h0);
    check("rst_mul_b", {16'h0, mul_b}, 32'h0);
    check("rst_mul_rst", {31'h0, mul_rst}, 32'h1);
    check("rst_busy", {31'h0, busy}, 32'h0);

    // 1: single pair, latency and one-cycle valid
    out_ready = 1'b1;
    push_one(16'd3, 16'd5);
    wait_valid(n);
    check("t1_latency", n, 32'd19);
    check("t1_res", {16'h0, res}, 32'd15);
    tick();
    check("t1_valid_drop", {31'h0, out_valid}, 32'h0);

    // 2: two pairs in order, back-to-back throughput
    push_one(16'h0100, 16'h0100);
    push_one(16'hFFFF, 16'h0002);
    wait_valid(n);
    check("t2_res0", {16'h0, res}, 32'h0000);
    tick();
    wait_valid(n);
    check("t2_gap", n, 32'd17);
    check("t2_res1", {16'h0, res}, 32'hFFFE);
    tick();
    check("t2_valid_drop", {31'h0, out_valid}, 32'h0);

    // 3: backpressure holds result, blocks the next run
    out_ready = 1'b0;
    push_one(16'd7, 16'd9);
    push_one(16'd2, 16'd3);
    wait_valid(n);
    check("t3_res", {16'h0, res}, 32'd63);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_hold_res", {16'h0, res}, 32'd63);
      check("t3_hold_valid", {31'h0, out_valid}, 32'h1);
      check("t3_hold_mulrst", {31'h0, mul_rst}, 32'h1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_rel_valid", {31'h0, out_valid}, 32'h0);
    check("t3_load_a", {16'h0, mul_a}, 32'd2);
    check("t3_load_b", {16'h0, mul_b}, 32'd3);
    check("t3_load_mulrst", {31'h0, mul_rst}, 32'h1);
    check("t3_load_busy", {31'h0, busy}, 32'h1);
    tick();
    check("t3_run_mulrst", {31'h0, mul_rst}, 32'h0);
    out_ready = 1'b1;
    wait_valid(n);
    check("t3_res2", {16'h0, res}, 32'd6);
    tick();
    check("t3_level", {29'h0, level}, 32'h0);

    // 4: fill the FIFO under backpressure
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_a = WIDTH'(2 * k + 1);
      in_b = WIDTH'(2 * k + 2);
      check("t4_in_ready", {31'h0, in_ready}, (k < 5) ? 32'h1 : 32'h0);
      tick();
    end
    in_valid = 1'b0;
    check("t4_level", {29'h0, level}, 32'd4);
    for (int k = 0; k < 5; k++) begin
      wait_valid(n);
      check("t4_res", {16'h0, res}, exp4[k]);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    check("t4_idle", {31'h0, busy}, 32'h0);

    // 5: reset in the middle of a run with two pairs queued
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_a = WIDTH'(k + 4);
      in_b = WIDTH'(k + 4);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("t5_running", {31'h0, mul_rst}, 32'h0);
    check("t5_queued", {29'h0, level}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", {31'h0, busy}, 32'h0);
    check("t5_level", {29'h0, level}, 32'h0);
    check("t5_valid", {31'h0, out_valid}, 32'h0);
    check("t5_mulrst", {31'h0, mul_rst}, 32'h1);
    check("t5_in_ready", {31'h0, in_ready}, 32'h1);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    check("t5_no_output", pulses, 32'h0);

    // 6: push coinciding with a DONE->LOAD pop at level 1
    out_ready = 1'b0;
    push_one(16'd10, 16'd11);
    push_one(16'd12, 16'd13);
    wait_valid(n);
    check("t6_res0", {16'h0, res}, 32'd110);
    check("t6_level_pre", {29'h0, level}, 32'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 16'd14;
    in_b      = 16'd15;
    tick();
    in_valid = 1'b0;
    check("t6_level_same", {29'h0, level}, 32'd1);
    check("t6_load_a", {16'h0, mul_a}, 32'd12);
    wait_valid(n);
    check("t6_res1", {16'h0, res}, 32'd156);
    tick();
    wait_valid(n);
    check("t6_res2", {16'h0, res}, 32'd210);
    tick();
    check("t6_idle", {31'h0, busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
